reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Synthesizable staged reset and clock-enable controller for the digital side of the ADC design. It holds every downstream block in reset, then releases each stage in order, enabling a stage's clock before its reset so that synchronous-reset logic sees clock edges while still in reset. It also accepts a soft-reset request that re-runs the full sequence without a global reset. It sits between the top-level clock/reset source and the ADC datapath blocks.

## Interface
- NUM_STAGES, 4: number of sequenced stages; stage 0 is released first.
- HOLD_CYCLES, 8: cycles all stages stay in reset before stage 0's clock is enabled; legal range 1..2^CNT_W-1.
- STAGE_DELAY, 4: cycles between consecutive sequence events; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the internal delay counter.
- RESET_ACTIVE, 1: asserted level driven on stage_rst.

- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high; has priority over every other input.
- soft_rst_req  in  1  single-cycle request to re-run the reset sequence.
- stage_rst  out  NUM_STAGES  per-stage reset; RESET_ACTIVE means the stage is held in reset.
- clk_en  out  NUM_STAGES  per-stage clock enable; 1 means the stage is enabled.
- busy  out  1  high while a sequence is in progress.
- done  out  1  high when all stages are released (RUN state).

## Operation
- All outputs are registered.
- Reset values (any edge with rst=1): stage_rst all RESET_ACTIVE, clk_en all 0, busy=1, done=0, state HOLD, counter 0, stage index 0.
- HOLD:
  - E0 is the entry edge into HOLD: the last edge with rst=1, or the edge where DRAIN asserts the resets.
  - The counter increments each cycle.
  - At E0+HOLD_CYCLES, set clk_en[0]=1 and go to SEQ with index k=0.
- SEQ:
  - Every STAGE_DELAY cycles, release stage_rst[k] (drive it to ~RESET_ACTIVE).
  - If k<NUM_STAGES-1, set clk_en[k+1]=1 on the same edge and increment k.
  - After releasing the last stage, go to RUN on the next edge.
  - General schedule: clk_en[k] rises at E0+HOLD_CYCLES+k*STAGE_DELAY; stage_rst[k] releases at E0+HOLD_CYCLES+(k+1)*STAGE_DELAY.
- RUN:
  - Entered at E0+HOLD_CYCLES+NUM_STAGES*STAGE_DELAY+1.
  - done=1, busy=0.
  - All clk_en=1; all stage_rst deasserted.
- DRAIN:
  - Entered from SEQ or RUN when soft_rst_req=1 is sampled.
  - Next edge: all clk_en=0, busy=1, done=0; stage_rst unchanged.
  - Following edge: all stage_rst=RESET_ACTIVE; enter HOLD (this edge is E0) with counter cleared and k=0.
- soft_rst_req handling by state:
  - HOLD or DRAIN: ignored, no restart or extension.
  - SEQ: aborts the sequence and goes to DRAIN.
- rst mid-sequence: overrides immediately on the same edge and restores reset values; the sequence restarts from HOLD.
- Once asserted in a sequence, clk_en bits never drop except through DRAIN or rst.
- Once released, stage_rst bits never re-assert except through DRAIN or rst.
- Invariant: clk_en[k]=0 implies stage_rst[k]=RESET_ACTIVE.
- Counter compares are exact equality; the counter never wraps within legal parameter ranges.

## Timing
- Release latency from E0 to done is HOLD_CYCLES+NUM_STAGES*STAGE_DELAY+1 edges. Defaults: 25 edges.
- Soft-reset latency:
  - request sampled at edge R: clk_en all 0 at R+1, resets asserted at R+2 (R+2 is E0).
  - done returns at R+2+HOLD_CYCLES+NUM_STAGES*STAGE_DELAY+1.
- busy and done are mutually exclusive and always complementary.
- rst and soft_rst_req both high on the same edge: rst wins; no DRAIN is entered.

## Test plan
- Power-on, defaults. rst=1 on edges 0..3, 0 after (E0=3).
  - Required: clk_en[0] rises at edge 11.
  - Required: stage_rst[0] releases and clk_en[1] rises at edge 15.
  - Required: stage_rst[3] releases at edge 27; done=1 and busy=0 at edge 28.
  - Required: invariant holds every cycle.
- Soft reset from RUN, pulse sampled at edge R.
  - Required: clk_en=0000 at R+1.
  - Required: stage_rst=1111 at R+2.
  - Required: done=1 again at R+27.
- Soft reset mid-SEQ, pulse while k=2.
  - Required: DRAIN at the next edge.
  - Required: all resets asserted one edge later.
  - Required: full 25-edge sequence from the new E0.
- Soft reset ignored. Pulses during HOLD and during DRAIN.
  - Required: schedule identical to the no-pulse schedule.
- rst mid-sequence. rst=1 for one edge while k=1.
  - Required: all outputs return to reset values on that edge.
  - Required: sequence completes 25 edges after it.
- Parameter corner: HOLD_CYCLES=1, STAGE_DELAY=1, NUM_STAGES=1, RESET_ACTIVE=0.
  - Required: clk_en[0] at E0+1; stage_rst[0]=1 at E0+2; done at E0+3.
  - Required: the reset value of stage_rst is 0.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset / clock-enable sequencer for the ADC digital side.
// Each stage gets its clock enabled STAGE_DELAY cycles before its reset is
// released, so synchronous-reset logic sees clock edges while still in reset.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES   = 4,
    parameter int unsigned HOLD_CYCLES  = 8,
    parameter int unsigned STAGE_DELAY  = 4,
    parameter int unsigned CNT_W        = 8,
    parameter logic        RESET_ACTIVE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_rst_req,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic [NUM_STAGES-1:0] clk_en,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned            IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       STEP_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0]  RST_ALL   = {NUM_STAGES{RESET_ACTIVE}};

    // ST_LAST is the one-cycle gap between the last release and RUN;
    // ST_DRAIN/ST_FLUSH are the two edges of a soft-reset drain.
    typedef enum logic [2:0] {
        ST_HOLD,
        ST_SEQ,
        ST_LAST,
        ST_RUN,
        ST_DRAIN,
        ST_FLUSH
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [NUM_STAGES-1:0]   stage_rst_q;
    logic [NUM_STAGES-1:0]   clk_en_q;
    logic                    busy_q;
    logic                    done_q;

    // Sequencer FSM with registered outputs; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            stage_rst_q <= RST_ALL;
            clk_en_q    <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        clk_en_q[0] <= 1'b1;
                        cnt_q       <= '0;
                        idx_q       <= '0;
                        state_q     <= ST_SEQ;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_SEQ: begin
                    if (soft_rst_req) begin
                        state_q <= ST_DRAIN;
                    end else if (cnt_q == STEP_LAST) begin
                        cnt_q <= '0;
                        // Release stage k and enable the clock of stage k+1.
                        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                stage_rst_q[i] <= ~RESET_ACTIVE;
                            end
                            if ((idx_q != IDX_LAST) && ((idx_q + IDX_W'(1)) == IDX_W'(i))) begin
                                clk_en_q[i] <= 1'b1;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_LAST;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_LAST: begin
                    if (soft_rst_req) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (soft_rst_req) begin
                        state_q <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    clk_en_q <= '0;
                    busy_q   <= 1'b1;
                    done_q   <= 1'b0;
                    state_q  <= ST_FLUSH;
                end

                ST_FLUSH: begin
                    stage_rst_q <= RST_ALL;
                    cnt_q       <= '0;
                    idx_q       <= '0;
                    state_q     <= ST_HOLD;
                end

                default: begin
                    state_q     <= ST_HOLD;
                    cnt_q       <= '0;
                    idx_q       <= '0;
                    stage_rst_q <= RST_ALL;
                    clk_en_q    <= '0;
                    busy_q      <= 1'b1;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign stage_rst = stage_rst_q;
    assign clk_en    = clk_en_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance (a) and a minimal corner
// instance (b: 1 stage, 1-cycle hold/delay, active-low reset).
// Expected output-change events are queued ahead of stimulus; a monitor pops
// one event each time the DUT outputs change and checks edge and values.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_rst_req;
    logic       rst_b;
    logic       soft_b;

    logic [3:0] a_srst;
    logic [3:0] a_cen;
    logic       a_busy;
    logic       a_done;
    logic [0:0] b_srst;
    logic [0:0] b_cen;
    logic       b_busy;
    logic       b_done;

    reset_sequencer dut_a (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_req (soft_rst_req),
        .stage_rst    (a_srst),
        .clk_en       (a_cen),
        .busy         (a_busy),
        .done         (a_done)
    );

    reset_sequencer #(
        .NUM_STAGES   (1),
        .HOLD_CYCLES  (1),
        .STAGE_DELAY  (1),
        .CNT_W        (8),
        .RESET_ACTIVE (1'b0)
    ) dut_b (
        .clk          (clk),
        .rst          (rst_b),
        .soft_rst_req (soft_b),
        .stage_rst    (b_srst),
        .clk_en       (b_cen),
        .busy         (b_busy),
        .done         (b_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic [3:0] srst;
        logic [3:0] cen;
        logic       busy;
        logic       done;
        string      tag;
    } snap_t;

    snap_t q_a[$];
    snap_t q_b[$];
    snap_t cur[2];
    snap_t s_pop;

    int   edge_n   = -1;
    int   n_checks = 0;
    int   n_err    = 0;
    bit   end_req  = 1'b0;
    bit   end_done = 1'b0;
    logic [9:0] prev_a;
    logic [9:0] prev_b;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Instance parameters, w=0 is dut_a, w=1 is dut_b.
    function automatic int p_n(input int w);
        return (w == 0) ? 4 : 1;
    endfunction
    function automatic int p_h(input int w);
        return (w == 0) ? 8 : 1;
    endfunction
    function automatic int p_d(input int w);
        return (w == 0) ? 4 : 1;
    endfunction
    function automatic logic p_ra(input int w);
        return (w == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic push(input int w, input int e, input string tag);
        snap_t s;
        s     = cur[w];
        s.e   = e;
        s.tag = tag;
        if (w == 0) q_a.push_back(s);
        else        q_b.push_back(s);
    endtask

    task automatic set_all_rst(input int w);
        cur[w].srst = '0;
        for (int k = 0; k < p_n(w); k++) cur[w].srst[k] = p_ra(w);
    endtask

    task automatic exp_reset(input int w, input int e);
        set_all_rst(w);
        cur[w].cen  = '0;
        cur[w].busy = 1'b1;
        cur[w].done = 1'b0;
        push(w, e, "reset");
    endtask

    // Release schedule from entry edge e0; events at or after stop are cut.
    task automatic exp_seq(input int w, input int e0, input int stop);
        int t;
        t = e0 + p_h(w);
        if (t < stop) begin
            cur[w].cen[0] = 1'b1;
            push(w, t, "clk_en0");
        end
        for (int k = 0; k < p_n(w); k++) begin
            t = e0 + p_h(w) + (k + 1) * p_d(w);
            if (t < stop) begin
                cur[w].srst[k] = ~p_ra(w);
                if (k < p_n(w) - 1) cur[w].cen[k+1] = 1'b1;
                push(w, t, $sformatf("release%0d", k));
            end
        end
        t = e0 + p_h(w) + p_n(w) * p_d(w) + 1;
        if (t < stop) begin
            cur[w].busy = 1'b0;
            cur[w].done = 1'b1;
            push(w, t, "done");
        end
    endtask

    task automatic exp_drain(input int w, input int r, input int stop);
        cur[w].cen  = '0;
        cur[w].busy = 1'b1;
        cur[w].done = 1'b0;
        push(w, r + 1, "drain_clk");
        set_all_rst(w);
        push(w, r + 2, "drain_rst");
        exp_seq(w, r + 2, stop);
    endtask

    task automatic check_evt(input string inst, input snap_t x,
                             input logic [3:0] srst, input logic [3:0] cen,
                             input logic busy, input logic done);
        n_checks++;
        if (x.e != edge_n || x.srst !== srst || x.cen !== cen ||
            x.busy !== busy || x.done !== done) begin
            n_err++;
            $display("FAIL %s_%s: got edge %0d stage_rst=%b clk_en=%b busy=%b done=%b, need edge %0d stage_rst=%b clk_en=%b busy=%b done=%b",
                     inst, x.tag, edge_n, srst, cen, busy, done,
                     x.e, x.srst, x.cen, x.busy, x.done);
        end
    endtask

    // Monitor: pops an expected event on every output change of each DUT.
    always @(negedge clk) begin
        if (edge_n >= 0) begin
            if ({a_srst, a_cen, a_busy, a_done} !== prev_a) begin
                prev_a = {a_srst, a_cen, a_busy, a_done};
                if (q_a.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL a_unexpected_change: edge %0d stage_rst=%b clk_en=%b busy=%b done=%b, need no change",
                             edge_n, a_srst, a_cen, a_busy, a_done);
                end else begin
                    s_pop = q_a.pop_front();
                    check_evt("a", s_pop, a_srst, a_cen, a_busy, a_done);
                end
            end
            if ({3'b000, b_srst, 3'b000, b_cen, b_busy, b_done} !== prev_b) begin
                prev_b = {3'b000, b_srst, 3'b000, b_cen, b_busy, b_done};
                if (q_b.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL b_unexpected_change: edge %0d stage_rst=%b clk_en=%b busy=%b done=%b, need no change",
                             edge_n, b_srst, b_cen, b_busy, b_done);
                end else begin
                    s_pop = q_b.pop_front();
                    check_evt("b", s_pop, {3'b000, b_srst}, {3'b000, b_cen}, b_busy, b_done);
                end
            end
            // Power-on pass through RUN: disabled clock implies held reset.
            if (edge_n <= 39) begin
                n_checks++;
                if ((~a_cen & ~a_srst) != 4'b0000) begin
                    n_err++;
                    $display("FAIL a_invariant: edge %0d clk_en=%b stage_rst=%b, need stage_rst high where clk_en low",
                             edge_n, a_cen, a_srst);
                end
            end
            if (end_req && !end_done) begin
                end_done = 1'b1;
                n_checks++;
                if (q_a.size() != 0) begin
                    n_err++;
                    $display("FAIL a_missing_events: %0d pending, next %s at edge %0d, need 0 pending",
                             q_a.size(), q_a[0].tag, q_a[0].e);
                end
                n_checks++;
                if (q_b.size() != 0) begin
                    n_err++;
                    $display("FAIL b_missing_events: %0d pending, next %s at edge %0d, need 0 pending",
                             q_b.size(), q_b[0].tag, q_b[0].e);
                end
            end
        end
    end

    // Inputs set here are sampled at edge e.
    task automatic drive_until(input int e);
        while (edge_n < e - 1) @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        soft_rst_req = 1'b0;
        rst_b        = 1'b1;
        soft_b       = 1'b0;

        // Power-on: rst on edges 0..3, E0 = 3, done at 28.
        exp_reset(0, 0);
        exp_seq(0, 3, 1000);
        // Corner instance: E0 = 3, then a soft reset from RUN at edge 20.
        exp_reset(1, 0);
        exp_seq(1, 3, 1000);
        exp_drain(1, 20, 1000);
        // Soft reset from RUN at 40; new sequence cut by next soft reset.
        exp_drain(0, 40, 60);
        // Mid-SEQ soft reset at 60 (k=2); pulses at 62 (drain) and 66 (hold) ignored.
        exp_drain(0, 60, 100);
        // Soft reset at 100, then rst for one edge at 116 while k=1.
        exp_drain(0, 100, 116);
        exp_reset(0, 116);
        exp_seq(0, 116, 150);
        // rst and soft request together at 150: plain reset, no drain.
        exp_reset(0, 150);
        exp_seq(0, 150, 1000);

        drive_until(4);
        rst   = 1'b0;
        rst_b = 1'b0;

        drive_until(20);  soft_b = 1'b1;
        drive_until(21);  soft_b = 1'b0;

        drive_until(40);  soft_rst_req = 1'b1;
        drive_until(41);  soft_rst_req = 1'b0;

        drive_until(60);  soft_rst_req = 1'b1;
        drive_until(61);  soft_rst_req = 1'b0;
        drive_until(62);  soft_rst_req = 1'b1;
        drive_until(63);  soft_rst_req = 1'b0;
        drive_until(66);  soft_rst_req = 1'b1;
        drive_until(67);  soft_rst_req = 1'b0;

        drive_until(100); soft_rst_req = 1'b1;
        drive_until(101); soft_rst_req = 1'b0;

        drive_until(116); rst = 1'b1;
        drive_until(117); rst = 1'b0;

        drive_until(150); rst = 1'b1; soft_rst_req = 1'b1;
        drive_until(151); rst = 1'b0; soft_rst_req = 1'b0;

        drive_until(190);
        end_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
